// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit
// per clock, and publishes {cout,sum} when the last bit has been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fa_s;

    // Returns {carry_out, sum_bit} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | ((x ^ y) & c), x ^ y ^ c};
    endfunction

    assign fa_s = full_add(a_sh_q[0], b_sh_q[0], carry_q);

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                // Shift-then-set keeps this legal for WIDTH=1.
                psum_d            = psum_q >> 1;
                psum_d[WIDTH-1]   = fa_s[0];
                carry_d           = fa_s[1];
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = psum_d;
                    cout_d  = fa_s[1];
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 1, 8 and 32.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [3];
    logic        cin_v   [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    wire  [2:0]  busy_w, done_w, cout_w;
    wire  [0:0]  sum1;
    wire  [7:0]  sum8;
    wire  [31:0] sum32;

    int          wv [3] = '{1, 8, 32};
    logic [31:0] exp_sum  [3];
    logic        exp_cout [3];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
        .cin(cin_v[0]), .busy(busy_w[0]), .done(done_w[0]), .sum(sum1), .cout(cout_w[0]));
    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .cin(cin_v[1]), .busy(busy_w[1]), .done(done_w[1]), .sum(sum8), .cout(cout_w[1]));
    serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .busy(busy_w[2]), .done(done_w[2]), .sum(sum32), .cout(cout_w[2]));

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0:       return {31'b0, sum1};
            1:       return {24'b0, sum8};
            default: return sum32;
        endcase
    endfunction

    // One operation on instance k; returns at the negedge after the DONE cycle,
    // so a following call issues at the minimum interval.
    task automatic op(input int k, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic hold, input string nm);
        int          w;
        int          n;
        logic [31:0] m;
        logic [32:0] e;
        logic [31:0] es;
        logic        ec;
        logic        stable;
        w  = wv[k];
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        e  = {1'b0, av & m} + {1'b0, bv & m} + {32'b0, cv};
        es = e[31:0] & m;
        ec = e[w];
        start_v[k] = 1'b1;
        a_v[k] = av;
        b_v[k] = bv;
        cin_v[k] = cv;
        @(negedge clk);
        n = 0;
        stable = 1'b1;
        if (!hold) start_v[k] = 1'b0;
        while (!done_w[k] && n < w + 3) begin
            if (get_sum(k) !== exp_sum[k] || cout_w[k] !== exp_cout[k]) stable = 1'b0;
            a_v[k] = $urandom;
            b_v[k] = $urandom;
            cin_v[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        total++;
        if (done_w[k] !== 1'b1 || n != w || get_sum(k) !== es || cout_w[k] !== ec)
            $display("FAIL %s w=%0d: got done=%b after %0d edges sum=%h cout=%b; want done=1 after %0d sum=%h cout=%b",
                     nm, w, done_w[k], n, get_sum(k), cout_w[k], w, es, ec);
        else passed++;
        total++;
        if (!stable)
            $display("FAIL %s_stable w=%0d: sum/cout moved before completion, want %h/%b held",
                     nm, w, exp_sum[k], exp_cout[k]);
        else passed++;
        exp_sum[k]  = es;
        exp_cout[k] = ec;
        @(negedge clk);
        total++;
        if (done_w[k] !== 1'b0 || busy_w[k] !== 1'b0 || get_sum(k) !== es || cout_w[k] !== ec)
            $display("FAIL %s_after w=%0d: got done=%b busy=%b sum=%h cout=%b; want 0 0 %h %b",
                     nm, w, done_w[k], busy_w[k], get_sum(k), cout_w[k], es, ec);
        else passed++;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; cin_v[k] = 1'b0; a_v[k] = 32'h0; b_v[k] = 32'h0;
            exp_sum[k] = 32'h0; exp_cout[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || get_sum(k) !== 32'h0 || cout_w[k] !== 1'b0)
                $display("FAIL reset k=%0d: got busy=%b done=%b sum=%h cout=%b; want all 0",
                         k, busy_w[k], done_w[k], get_sum(k), cout_w[k]);
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        op(1, 32'h5A, 32'h3C, 1'b0, 1'b0, "add_5a_3c");
        op(1, 32'hFF, 32'h01, 1'b0, 1'b0, "add_ff_01");
        op(1, 32'hFF, 32'hFF, 1'b1, 1'b0, "add_ff_ff_c");
        op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "add32_wrap");
        op(2, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, "add32_mix");
    endtask

    task automatic test_width1();
        op(0, 32'h1, 32'h1, 1'b1, 1'b0, "w1_111");
        op(0, 32'h1, 32'h0, 1'b0, 1'b0, "w1_100");
        op(0, 32'h0, 32'h0, 1'b1, 1'b0, "w1_001");
    endtask

    task automatic test_mid_reset();
        logic saw;
        start_v[1] = 1'b1; a_v[1] = 32'h5A; b_v[1] = 32'h3C; cin_v[1] = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0 || sum8 !== 8'h00 || cout_w[1] !== 1'b0)
            $display("FAIL mid_reset_async: got busy=%b done=%b sum=%h cout=%b; want all 0",
                     busy_w[1], done_w[1], sum8, cout_w[1]);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            exp_sum[k] = 32'h0; exp_cout[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            if (done_w[1] !== 1'b0 || busy_w[1] !== 1'b0) saw = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw || sum8 !== 8'h00 || cout_w[1] !== 1'b0)
            $display("FAIL mid_reset_quiet: got activity=%b sum=%h cout=%b; want 0 00 0",
                     saw, sum8, cout_w[1]);
        else passed++;
        op(1, 32'h12, 32'h34, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [6] = '{32'h01, 32'h80, 32'hF0, 32'h0F, 32'hAA, 32'h7F};
        for (int i = 0; i < 6; i++)
            op(1, ops[i], ops[5 - i] ^ 32'h33, 1'(i % 2), 1'b1, "b2b");
        start_v[1] = 1'b0;
        for (int i = 0; i < 3; i++)
            op(0, 32'(i), 32'(i + 1), 1'(i % 2), 1'b1, "b2b_w1");
        start_v[0] = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++)
            op(i % 3, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "rand");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_width1();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
